// File: rtl/lsqueue_gen_pkg.sv
// Shared RISC-V load/store definitions: funct3 encodings, size codes, legality helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package lsqueue_gen_pkg;

  // Load funct3 encodings; stores reuse the low two bits as the size code.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  function automatic logic xlen_legal(input int xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  // Unencodable funct3 values are folded into the misaligned rejection path.
  function automatic logic f3_legal(input logic is_st, input logic [2:0] f3, input int xlen);
    logic ok;
    ok = (f3 != 3'b111) && !(is_st && f3[2]);
    if ((xlen == 32) && ((f3 == F3_D) || (f3 == F3_WU))) ok = 1'b0;
    return ok;
  endfunction

  // Address bits that must be zero for an access of the given size.
  function automatic logic [2:0] align_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'b000;
      SZ_H:    return 3'b001;
      SZ_W:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/fifo_gen.sv
// Generic synchronous FIFO with flush and occupancy count.
// Latency: push visible at data_o the cycle after the write; pop is a pointer advance.
// Backpressure: push while full is accepted only when a pop happens in the same cycle.
// Ports: clk_i/reset_i (async, active-high), flush_i clears pointers, push_i/data_i write,
//        pop_i advances head, data_o is the head entry, count_o is the occupancy.
module fifo_gen #(
  parameter int C_WIDTH   = 8,
  parameter int C_DEPTH_X = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [C_WIDTH-1:0] data_i,
  input  logic               pop_i,
  output logic [C_WIDTH-1:0] data_o,
  output logic [C_DEPTH_X:0] count_o
);
  localparam int C_DEPTH = 1 << C_DEPTH_X;
  localparam int C_PW    = C_DEPTH_X + 1;

  if (C_DEPTH_X < 1) begin : g_depth_chk
    $error("fifo_gen: C_DEPTH_X must be at least 1");
  end

  logic [C_WIDTH-1:0] r_mem [C_DEPTH];
  logic [C_PW-1:0]    r_wr_ptr;
  logic [C_PW-1:0]    r_rd_ptr;
  logic               w_full;
  logic               w_wr;
  logic               w_rd;

  assign count_o = r_wr_ptr - r_rd_ptr;
  assign w_full  = (count_o == C_PW'(C_DEPTH));
  assign w_wr    = push_i & (~w_full | pop_i);
  assign w_rd    = pop_i & (count_o != '0);
  assign data_o  = r_mem[r_rd_ptr[C_DEPTH_X-1:0]];

  // Storage is reset so the head reads as zero out of reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < C_DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr[C_DEPTH_X-1:0]] <= data_i;
        r_wr_ptr <= r_wr_ptr + C_PW'(1);
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + C_PW'(1);
    end
  end

endmodule

// File: rtl/lsqueue_gen.sv
// In-order load/store queue: request FIFO to memory, response-control FIFO for writeback.
// Latency: enqueue->dreqvalid 1 cycle; response->lsq_reg_wr 1 cycle (registered).
// Backpressure: exs_full_o when request FIFO full; issue stalls on dreqready_i low or max outstanding.
// Ports: exs_* enqueue side, lsq_reg_* writeback, plic_int_* fault pulses, dreq*/drsp* memory port.
module lsqueue_gen
  import lsqueue_gen_pkg::*;
#(
  parameter int C_XLEN        = 32,
  parameter int C_REQ_DEPTH_X = 2,
  parameter int C_RSP_DEPTH_X = 2
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clk_en_i,
  input  logic                flush_i,
  input  logic                exs_lq_wr_i,
  input  logic                exs_sq_wr_i,
  input  logic [2:0]          exs_funct3_i,
  input  logic [1:0]          exs_hpl_i,
  input  logic [4:0]          exs_regd_addr_i,
  input  logic [C_XLEN-1:0]   exs_addr_i,
  input  logic [C_XLEN-1:0]   exs_regs2_data_i,
  output logic                exs_full_o,
  output logic                exs_empty_o,
  output logic                exs_misaligned_o,
  output logic                lsq_reg_wr_o,
  output logic [4:0]          lsq_reg_addr_o,
  output logic [C_XLEN-1:0]   lsq_reg_data_o,
  output logic                plic_int_laf_o,
  output logic                plic_int_saf_o,
  input  logic                dreqready_i,
  output logic                dreqvalid_o,
  output logic                dreqwrite_o,
  output logic [1:0]          dreqsize_o,
  output logic [1:0]          dreqhpl_o,
  output logic [C_XLEN/8-1:0] dreqbe_o,
  output logic [C_XLEN-1:0]   dreqaddr_o,
  output logic [C_XLEN-1:0]   dreqdata_o,
  output logic                drspready_o,
  input  logic                drspvalid_i,
  input  logic                drsprerr_i,
  input  logic                drspwerr_i,
  input  logic [C_XLEN-1:0]   drspdata_i
);
  localparam int C_NB  = C_XLEN / 8;
  localparam int C_LO  = $clog2(C_NB);
  localparam int C_QW  = C_REQ_DEPTH_X + 1;
  localparam int C_KW  = C_RSP_DEPTH_X + 1;

  if (!xlen_legal(C_XLEN)) begin : g_xlen_chk
    $error("lsqueue_gen: C_XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic              write;
    logic [2:0]        funct3;
    logic [1:0]        hpl;
    logic [4:0]        regd;
    logic [C_XLEN-1:0] addr;
    logic [C_XLEN-1:0] data;
  } req_t;

  typedef struct packed {
    logic            write;
    logic [C_LO-1:0] lo;
    logic [4:0]      regd;
    logic [2:0]      funct3;
  } rspc_t;

  req_t              w_req_in, w_req_head;
  rspc_t             w_rspc_in, w_rspc_head;
  logic [C_QW-1:0]   w_req_cnt;
  logic [C_KW-1:0]   w_rsp_cnt;
  logic              w_enq, w_misal, w_flush, w_req_push, w_req_pop, w_rsp_pop;
  logic              w_req_empty, w_req_full, w_rsp_empty, w_rsp_full, w_live;
  logic [C_LO-1:0]   w_lo;
  logic [C_NB-1:0]   w_mask;
  logic [C_XLEN-1:0] w_ld_sh, w_ld_data;
  logic [C_KW-1:0]   r_kill;
  logic              r_reg_wr, r_laf, r_saf, r_misal;
  logic [4:0]        r_reg_addr;
  logic [C_XLEN-1:0] r_reg_data;

  // Enqueue side; flush in the same cycle discards the enqueue.
  assign w_enq      = exs_lq_wr_i | exs_sq_wr_i;
  assign w_misal    = w_enq & (~f3_legal(exs_sq_wr_i, exs_funct3_i, C_XLEN) |
                               ((exs_addr_i[2:0] & align_mask(exs_funct3_i[1:0])) != 3'b000));
  assign w_flush    = clk_en_i & flush_i;
  assign w_req_push = clk_en_i & w_enq & ~w_misal & ~flush_i;
  assign w_req_in   = '{write: exs_sq_wr_i, funct3: exs_funct3_i, hpl: exs_hpl_i,
                        regd: exs_regd_addr_i, addr: exs_addr_i, data: exs_regs2_data_i};

  fifo_gen #(.C_WIDTH($bits(req_t)), .C_DEPTH_X(C_REQ_DEPTH_X)) u_req_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(w_flush),
    .push_i(w_req_push), .data_i(w_req_in), .pop_i(w_req_pop),
    .data_o(w_req_head), .count_o(w_req_cnt)
  );

  assign w_req_empty = (w_req_cnt == '0);
  assign w_req_full  = (w_req_cnt == C_QW'(1 << C_REQ_DEPTH_X));
  assign w_rsp_empty = (w_rsp_cnt == '0);
  assign w_rsp_full  = (w_rsp_cnt == C_KW'(1 << C_RSP_DEPTH_X));

  // Issue side; valid is also gated by clk_en_i so a frozen block never completes a handshake.
  assign dreqvalid_o = clk_en_i & ~flush_i & ~w_req_empty & ~w_rsp_full;
  assign w_req_pop   = dreqvalid_o & dreqready_i;
  assign w_lo        = w_req_head.addr[C_LO-1:0];
  assign dreqwrite_o = w_req_head.write;
  assign dreqsize_o  = w_req_head.funct3[1:0];
  assign dreqhpl_o   = w_req_head.hpl;
  assign dreqaddr_o  = w_req_head.addr;
  assign dreqbe_o    = w_mask << w_lo;

  always_comb begin
    w_mask     = C_NB'(8'hFF);
    dreqdata_o = w_req_head.data;
    case (w_req_head.funct3[1:0])
      SZ_B: begin w_mask = C_NB'(1);  dreqdata_o = {(C_NB){w_req_head.data[7:0]}};      end
      SZ_H: begin w_mask = C_NB'(3);  dreqdata_o = {(C_NB/2){w_req_head.data[15:0]}};   end
      SZ_W: begin w_mask = C_NB'(15); dreqdata_o = {(C_NB/4){w_req_head.data[31:0]}};   end
      default: ;
    endcase
  end

  // Response-control FIFO is never flushed: killed entries drain through the kill counter.
  assign w_rspc_in = '{write: w_req_head.write, lo: w_lo, regd: w_req_head.regd,
                       funct3: w_req_head.funct3};

  fifo_gen #(.C_WIDTH($bits(rspc_t)), .C_DEPTH_X(C_RSP_DEPTH_X)) u_rsp_fifo (
    .clk_i(clk_i), .reset_i(reset_i), .flush_i(1'b0),
    .push_i(w_req_pop), .data_i(w_rspc_in), .pop_i(w_rsp_pop),
    .data_o(w_rspc_head), .count_o(w_rsp_cnt)
  );

  assign drspready_o = drspvalid_i & ~w_rsp_empty;
  assign w_rsp_pop   = clk_en_i & drspready_o;
  assign w_live      = w_rsp_pop & (r_kill == '0);

  always_comb begin
    w_ld_sh = drspdata_i >> {w_rspc_head.lo, 3'b000};
    case (w_rspc_head.funct3)
      F3_B:    w_ld_data = C_XLEN'($signed(w_ld_sh[7:0]));
      F3_H:    w_ld_data = C_XLEN'($signed(w_ld_sh[15:0]));
      F3_W:    w_ld_data = C_XLEN'($signed(w_ld_sh[31:0]));
      F3_BU:   w_ld_data = C_XLEN'(w_ld_sh[7:0]);
      F3_HU:   w_ld_data = C_XLEN'(w_ld_sh[15:0]);
      F3_WU:   w_ld_data = C_XLEN'(w_ld_sh[31:0]);
      default: w_ld_data = w_ld_sh;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_kill     <= '0;
      r_reg_wr   <= 1'b0;
      r_laf      <= 1'b0;
      r_saf      <= 1'b0;
      r_misal    <= 1'b0;
      r_reg_addr <= '0;
      r_reg_data <= '0;
    end else if (clk_en_i) begin
      // Every entry still outstanding at the flush predates it; the one popped now is not killed.
      if (flush_i)                        r_kill <= w_rsp_cnt - C_KW'(w_rsp_pop);
      else if (w_rsp_pop && r_kill != '0) r_kill <= r_kill - C_KW'(1);
      r_reg_wr <= w_live & ~w_rspc_head.write;
      r_laf    <= w_live & ~w_rspc_head.write & drsprerr_i;
      r_saf    <= w_live & w_rspc_head.write & drspwerr_i;
      r_misal  <= w_misal & ~flush_i;
      if (w_live && !w_rspc_head.write) begin
        r_reg_addr <= w_rspc_head.regd;
        r_reg_data <= drsprerr_i ? '0 : w_ld_data;
      end
    end
  end

  assign lsq_reg_wr_o     = r_reg_wr;
  assign lsq_reg_addr_o   = r_reg_addr;
  assign lsq_reg_data_o   = r_reg_data;
  assign plic_int_laf_o   = r_laf;
  assign plic_int_saf_o   = r_saf;
  assign exs_misaligned_o = r_misal;
  assign exs_full_o       = w_req_full;
  assign exs_empty_o      = w_req_empty & w_rsp_empty & (r_kill == '0) & ~r_reg_wr;

endmodule

// File: doc/lsqueue_gen.md
LSQUEUE_GEN -- requirements
Module: lsqueue_gen

Interface
REQ-001 SHALL have parameter C_XLEN, default 32, data/address width; legal values 32 or 64, any other value is an elaboration error.
REQ-002 SHALL have parameter C_REQ_DEPTH_X, default 2, log2 depth of the request FIFO.
REQ-003 SHALL have parameter C_RSP_DEPTH_X, default 2, log2 depth of the response-control FIFO, which bounds outstanding requests.
REQ-004 Ports, clock and reset first:
  clk_i  in  1  clock; single clock domain.
  reset_i  in  1  reset; asynchronous, active-high.
  clk_en_i  in  1  global clock enable; all state holds when low.
  flush_i  in  1  pipeline flush.
  exs_lq_wr_i, exs_sq_wr_i  in  1  enqueue load / store; never both high.
  exs_funct3_i  in  3  RISC-V load/store funct3.
  exs_hpl_i  in  2  privilege level.
  exs_regd_addr_i  in  5  load destination register.
  exs_addr_i, exs_regs2_data_i  in  C_XLEN  address, store data.
  exs_full_o, exs_empty_o  out  1  request FIFO full; block idle.
  exs_misaligned_o  out  1  enqueue rejected as misaligned.
  lsq_reg_wr_o  out  1  writeback strobe.
  lsq_reg_addr_o  out  5  writeback register.
  lsq_reg_data_o  out  C_XLEN  writeback data.
  plic_int_laf_o, plic_int_saf_o  out  1  load / store access fault pulse.
  dreqready_i  in  1  request ready.
  dreqvalid_o, dreqwrite_o  out  1  request valid, write.
  dreqsize_o, dreqhpl_o  out  2  size, privilege.
  dreqbe_o  out  C_XLEN/8  byte enables.
  dreqaddr_o, dreqdata_o  out  C_XLEN  address, data.
  drspready_o  out  1  response ready.
  drspvalid_i, drsprerr_i, drspwerr_i  in  1  response valid, read error, write error.
  drspdata_i  in  C_XLEN  response data.

Function
REQ-005 Enqueue SHALL occur on lq_wr|sq_wr while clk_en_i=1, exs_full_o=0 and the access is aligned; an enqueue attempted while full is dropped and is an illegal stimulus.
REQ-006 The block SHALL reject any access whose address is not aligned to its size, pulsing exs_misaligned_o for one cycle and pushing nothing.
REQ-007 funct3 011/110 (LD/SD, LWU) SHALL be treated as misaligned-illegal when C_XLEN=32.
REQ-008 Issue SHALL assert dreqvalid_o when the request FIFO is non-empty, the response-control FIFO is not full and flush_i=0; a transfer occurs on valid&ready; dreqvalid_o and the request fields SHALL stay stable until the transfer completes.
REQ-009 Issue: dreqaddr_o SHALL be the full address; dreqbe_o SHALL be the size mask shifted by addr[log2(C_XLEN/8)-1:0]; dreqdata_o SHALL be the store data replicated into every lane of its size.
REQ-010 Every transfer SHALL push {write, addr low bits, regd, funct3} into the response-control FIFO; responses SHALL return strictly in order, exactly one per request.
REQ-011 drspready_o SHALL equal drspvalid_i & ~rsp_ctrl_empty.
REQ-012 A load response SHALL be registered one cycle later as lsq_reg_wr_o=1, with data right-justified by the stored low address bits and sign/zero-extended per funct3 (LB/LH/LW/LBU/LHU/LWU/LD).
REQ-013 A read error SHALL produce writeback data 0 plus a one-cycle plic_int_laf_o; a store response SHALL produce no writeback, and plic_int_saf_o pulses iff drspwerr_i.
REQ-014 Flush SHALL empty the request FIFO in the same cycle, forcing dreqvalid_o=0 in that cycle.
REQ-015 On flush, a kill counter SHALL load the current response-control occupancy, less any entry popped that cycle; each later response decrements it and is consumed silently, with no writeback and no fault.
REQ-016 A flush arriving while the kill counter is nonzero SHALL reload the counter with the full occupancy.
REQ-017 Enqueue and flush in the same cycle: flush wins and the enqueue is discarded.
REQ-018 Push and pop in the same cycle SHALL be legal for both FIFOs at full and at empty.
REQ-019 exs_empty_o SHALL equal both FIFOs empty & kill counter==0 & ~lsq_reg_wr_o.

Reset
REQ-020 Asserting reset_i SHALL asynchronously clear FIFO pointers and the kill counter, and drive lsq_reg_wr_o, all fault pulses, exs_misaligned_o and dreqvalid_o to 0.
REQ-021 lsq_reg_data_o, lsq_reg_addr_o and all dreq fields SHALL reset to 0, with exs_empty_o=1.
REQ-022 Reset mid-transaction SHALL abandon all outstanding responses; the environment also resets the memory port.

Structure
REQ-023 funct3 encodings, size codes and the C_XLEN legality check SHALL live in a shared riscv package/defines file.
REQ-024 Both queues SHALL instantiate one generic parametrised FIFO sub-module, fifo_gen (width, depth, flush, async active-high reset).

Verification
REQ-025 C_XLEN=32, LB at 0x1003 with response data 0x80FF_FF00 -> one cycle later lsq_reg_wr_o=1, lsq_reg_data_o=0xFFFF_FF80.
REQ-026 C_XLEN=32, SH at 0x2002 with data 0x1234ABCD -> dreqbe_o=4'b1100, dreqdata_o=0xABCD_ABCD.
REQ-027 C_XLEN=64, LWU at 0x...4 with response 0xFFFF_FFFF_0000_0000 -> lsq_reg_data_o=0x0000_0000_FFFF_FFFF.
REQ-028 LW at 0x1001 -> exs_misaligned_o pulses, no request issued, exs_empty_o stays 1.
REQ-029 Three loads issued, two queued, then flush_i -> no further requests issued, the next 3 responses produce no writeback, then exs_empty_o=1.
REQ-030 Fill the request FIFO to 4 with dreqready_i=0 -> exs_full_o=1; release ready with a simultaneous enqueue -> no loss, order preserved.
